// File: rtl/sha2_kconst_if.sv
// sha2_kconst_if: stream interface between the SHA-2 round-constant sequencer
// and its consumer.
//   master : the sequencer. It takes start/mode/abort/k_ready and drives the
//            k_* beat, busy and err.
//   slave  : the consumer / controller. It has the opposite directions.
interface sha2_kconst_if #(parameter int OUT_W = 64);
   logic             start;
   logic             mode;
   logic             abort;
   logic             k_ready;
   logic             k_valid;
   logic [OUT_W-1:0] k_data;
   logic [6:0]       k_idx;
   logic             k_last;
   logic             busy;
   logic             err;

   modport master (input  start, mode, abort, k_ready,
                   output k_valid, k_data, k_idx, k_last, busy, err);
   modport slave  (output start, mode, abort, k_ready,
                   input  k_valid, k_data, k_idx, k_last, busy, err);
endinterface

// File: rtl/sha2_kconst_seq.sv
// sha2_kconst_seq: streams the SHA-2 round constants K_0..K_{N-1} over a
// valid/ready interface, one constant per accepted beat.
//   clk, rst_n : clock; asynchronous active-low reset
//   kif        : sha2_kconst_if.master
//                start/mode (mode is sampled at start), abort, k_ready in
//                k_valid/k_data/k_idx/k_last beat, busy, err (illegal mode) out
// One 80-entry SHA-512 table serves both families. SHA-256 K_t is the upper
// word of SHA-512 K_t, so mode 0 uses bits [63:32] of the first 64 entries.
// OUT_W must be 32 or 64. Mode 1 needs OUT_W == 64.
module sha2_kconst_seq #(
   parameter int OUT_W = 64
) (
   input  logic          clk,
   input  logic          rst_n,
   sha2_kconst_if.master kif
);
   typedef enum logic {IDLE, RUN} state_t;

   localparam logic [63:0] K512 [0:79] = '{
      64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
      64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
      64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
      64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
      64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
      64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
      64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
      64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
      64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
      64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
      64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
      64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
      64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
      64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
      64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
      64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
      64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
      64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
      64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
      64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
   };

   state_t           state, state_n;
   logic             mode_q, mode_n;
   logic [6:0]       idx, idx_n;
   logic [OUT_W-1:0] data_q, data_n;
   logic             last_q, last_n;
   logic             err_q, err_n;
   logic [63:0]      kt;

   function automatic logic [6:0] final_idx(input logic m);
      return m ? 7'd79 : 7'd63;
   endfunction

   always_comb begin
      state_n = state;
      mode_n  = mode_q;
      idx_n   = idx;
      err_n   = 1'b0;
      case (state)
         IDLE: begin
            if (kif.start) begin
               if (kif.mode && OUT_W == 32) begin
                  err_n = 1'b1;
               end else begin
                  state_n = RUN;
                  mode_n  = kif.mode;
                  idx_n   = 7'd0;
               end
            end
         end
         RUN: begin
            // Abort wins over a coincident handshake. That beat counts as consumed.
            if (kif.abort) begin
               state_n = IDLE;
               idx_n   = 7'd0;
            end else if (kif.k_ready) begin
               if (idx == final_idx(mode_q)) begin
                  state_n = IDLE;
                  idx_n   = 7'd0;
               end else begin
                  idx_n = idx + 7'd1;
               end
            end
         end
         default: state_n = IDLE;
      endcase

      // The beat is registered from the next index, so a stall leaves data, idx
      // and last unchanged. Outside RUN the beat is all zero.
      kt     = K512[idx_n];
      data_n = '0;
      last_n = 1'b0;
      if (state_n == RUN) begin
         data_n = mode_n ? kt[OUT_W-1:0] : OUT_W'(kt[63:32]);
         last_n = (idx_n == final_idx(mode_n));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         mode_q <= 1'b0;
         idx    <= 7'd0;
         data_q <= '0;
         last_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         state  <= state_n;
         mode_q <= mode_n;
         idx    <= idx_n;
         data_q <= data_n;
         last_q <= last_n;
         err_q  <= err_n;
      end
   end

   // Every RUN cycle presents a beat, so valid and busy both follow the state flop.
   assign kif.k_valid = (state == RUN);
   assign kif.busy    = (state == RUN);
   assign kif.k_data  = data_q;
   assign kif.k_idx   = idx;
   assign kif.k_last  = last_q;
   assign kif.err     = err_q;
endmodule

// File: tb/tb_sha2_kconst_seq.sv
module tb_sha2_kconst_seq;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   sha2_kconst_if #(.OUT_W(64)) if64 ();
   sha2_kconst_if #(.OUT_W(32)) if32 ();

   sha2_kconst_seq #(.OUT_W(64)) u64 (.clk(clk), .rst_n(rst_n), .kif(if64));
   sha2_kconst_seq #(.OUT_W(32)) u32 (.clk(clk), .rst_n(rst_n), .kif(if32));

   // FIPS 180-4 SHA-512 constants; the SHA-256 set is the upper word of each.
   localparam logic [63:0] KT [0:79] = '{
      64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
      64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
      64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
      64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
      64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
      64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
      64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
      64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
      64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
      64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
      64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
      64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
      64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
      64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
      64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
      64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
      64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
      64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
      64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
      64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
   };

   int checks = 0;
   int errors = 0;

   // Model per DUT (0 = 64-bit, 1 = 32-bit): whether a run is active, which
   // round should be on the bus, the run's mode, and the err expected this cycle.
   bit m_run  [2];
   int m_t    [2];
   bit m_mode [2];
   bit m_err  [2];
   int hs_cnt [2];
   int last_cnt [2];

   function automatic logic [63:0] kexp(input int t, input bit md);
      logic [63:0] k;
      k = KT[t];
      return md ? k : {32'h0, k[63:32]};
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   // Compare the outputs with the model for this cycle. Then advance the model
   // from the inputs the DUT samples at the next rising edge.
   task automatic step(input int d, input logic st, md, ab, rdy,
                       input logic vld, bsy, lst, er,
                       input logic [63:0] dat, input logic [6:0] ix, input int w);
      int n;
      bit en;
      if (!rst_n) begin
         m_run[d] = 0; m_t[d] = 0; m_mode[d] = 0; m_err[d] = 0;
      end
      n = m_mode[d] ? 80 : 64;
      chk($sformatf("dut%0d k_valid", d), 64'(vld), 64'(m_run[d]));
      chk($sformatf("dut%0d busy", d),    64'(bsy), 64'(m_run[d]));
      chk($sformatf("dut%0d k_idx", d),   64'(ix),  m_run[d] ? 64'(m_t[d]) : 64'd0);
      chk($sformatf("dut%0d k_data", d),  dat,      m_run[d] ? kexp(m_t[d], m_mode[d]) : 64'd0);
      chk($sformatf("dut%0d k_last", d),  64'(lst), 64'(m_run[d] && m_t[d] == n - 1));
      chk($sformatf("dut%0d err", d),     64'(er),  64'(m_err[d]));
      if (vld === 1'b1 && lst === 1'b1) last_cnt[d]++;
      if (rst_n) begin
         en = 0;
         if (!m_run[d]) begin
            if (st) begin
               if (md && w == 32) en = 1;
               else begin m_run[d] = 1; m_t[d] = 0; m_mode[d] = md; end
            end
         end else if (ab) begin
            m_run[d] = 0;
         end else if (rdy) begin
            hs_cnt[d]++;
            if (m_t[d] == n - 1) m_run[d] = 0;
            else m_t[d]++;
         end
         m_err[d] = en;
      end
   endtask

   always @(negedge clk) begin
      step(0, if64.start, if64.mode, if64.abort, if64.k_ready,
           if64.k_valid, if64.busy, if64.k_last, if64.err, if64.k_data, if64.k_idx, 64);
      step(1, if32.start, if32.mode, if32.abort, if32.k_ready,
           if32.k_valid, if32.busy, if32.k_last, if32.err, 64'(if32.k_data), if32.k_idx, 32);
   end

   task automatic cyc();
      @(posedge clk); #1;
   endtask

   task automatic wait_idle64(input string nm, input int bound);
      int c = 0;
      while (if64.busy === 1'b1 && c < bound) begin cyc(); c++; end
      if (if64.busy !== 1'b0) chk({nm, " timeout"}, 64'(if64.busy), 64'd0);
   endtask

   task automatic wait_idx64(input int t, input int bound);
      int c = 0;
      while (if64.k_idx !== 7'(t) && c < bound) begin cyc(); c++; end
      if (if64.k_idx !== 7'(t)) chk("wait idx timeout", 64'(if64.k_idx), 64'(t));
   endtask

   initial begin
      int h0, l0;
      bit done;
      if64.start = 0; if64.mode = 0; if64.abort = 0; if64.k_ready = 0;
      if32.start = 0; if32.mode = 0; if32.abort = 0; if32.k_ready = 0;
      repeat (3) cyc();
      chk("reset k_valid", 64'(if64.k_valid), 64'd0);
      chk("reset k_data",  if64.k_data, 64'd0);
      @(posedge clk); #3 rst_n = 1;
      repeat (2) cyc();

      // 1: SHA-256 order, consumer always ready
      l0 = last_cnt[0];
      if64.k_ready = 1; if64.mode = 0; if64.start = 1;
      cyc(); if64.start = 0;
      chk("t1 k0", if64.k_data, 64'h00000000428a2f98);
      chk("t1 idx0", 64'(if64.k_idx), 64'd0);
      repeat (63) cyc();
      chk("t1 k63", if64.k_data, 64'h00000000c67178f2);
      chk("t1 last63", 64'(if64.k_last), 64'd1);
      cyc();
      chk("t1 busy after", 64'(if64.busy), 64'd0);
      chk("t1 last count", 64'(last_cnt[0] - l0), 64'd1);
      cyc();

      // 2: SHA-512 order
      l0 = last_cnt[0];
      if64.mode = 1; if64.start = 1;
      cyc(); if64.start = 0;
      chk("t2 k0", if64.k_data, 64'h428a2f98d728ae22);
      cyc();
      chk("t2 k1", if64.k_data, 64'h7137449123ef65cd);
      repeat (78) cyc();
      chk("t2 k79", if64.k_data, 64'h6c44198c4a475817);
      chk("t2 idx79", 64'(if64.k_idx), 64'd79);
      chk("t2 last79", 64'(if64.k_last), 64'd1);
      cyc();
      chk("t2 busy after", 64'(if64.busy), 64'd0);
      chk("t2 last count", 64'(last_cnt[0] - l0), 64'd1);
      cyc();

      // 3: SHA-256 with a consumer that stalls about half the time
      h0 = hs_cnt[0];
      if64.mode = 0; if64.start = 1; if64.k_ready = 0;
      cyc(); if64.start = 0;
      done = 0;
      for (int c = 0; c < 1500 && !done; c++) begin
         if64.k_ready = 1'($urandom_range(0, 1));
         cyc();
         if (if64.busy === 1'b0) done = 1;
      end
      chk("t3 finished", 64'(done), 64'd1);
      chk("t3 beats", 64'(hs_cnt[0] - h0), 64'd64);
      if64.k_ready = 1;
      cyc();

      // 4: abort on the same cycle as the handshake of t=10, then restart
      if64.start = 1;
      cyc(); if64.start = 0;
      wait_idx64(10, 20);
      if64.abort = 1;
      cyc(); if64.abort = 0;
      chk("t4 valid", 64'(if64.k_valid), 64'd0);
      chk("t4 busy", 64'(if64.busy), 64'd0);
      if64.start = 1;
      cyc(); if64.start = 0;
      chk("t4 restart idx", 64'(if64.k_idx), 64'd0);
      chk("t4 restart k0", if64.k_data, 64'h00000000428a2f98);
      wait_idle64("t4", 100);
      cyc();

      // 5: 32-bit build rejects SHA-512, streams SHA-256, ignores start in RUN
      if32.mode = 1; if32.start = 1;
      cyc(); if32.start = 0;
      chk("t5 err", 64'(if32.err), 64'd1);
      chk("t5 err no valid", 64'(if32.k_valid), 64'd0);
      cyc();
      chk("t5 err one cycle", 64'(if32.err), 64'd0);
      if32.mode = 0; if32.k_ready = 1; if32.start = 1;
      cyc(); if32.start = 0;
      repeat (5) cyc();
      chk("t5 k5", 64'(if32.k_data), 64'h59f111f1);
      if32.mode = 1; if32.start = 1;
      repeat (2) cyc();
      if32.start = 0;
      chk("t5 start in run err", 64'(if32.err), 64'd0);
      chk("t5 start in run idx", 64'(if32.k_idx), 64'd7);
      repeat (60) cyc();
      chk("t5 done", 64'(if32.busy), 64'd0);
      cyc();

      // 6: reset asserted mid-run while stalled on t=30
      if64.mode = 0; if64.start = 1; if64.k_ready = 1;
      cyc(); if64.start = 0;
      wait_idx64(30, 40);
      if64.k_ready = 0;
      cyc();
      @(posedge clk); #3 rst_n = 0;
      #1;
      chk("t6 async valid", 64'(if64.k_valid), 64'd0);
      chk("t6 async data", if64.k_data, 64'd0);
      chk("t6 async idx", 64'(if64.k_idx), 64'd0);
      chk("t6 async busy", 64'(if64.busy), 64'd0);
      @(posedge clk); #3 rst_n = 1;
      repeat (3) cyc();
      chk("t6 post valid", 64'(if64.k_valid), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
